cpu_memory_stage: RTL and testbench

- Pipeline stage directly downstream of the combinational execute unit. It registers the execute result and performs MIPS loads and stores over a simple req/ack data bus.
- It also determines the writeback register and exception code, and presents one registered writeback record per instruction to the writeback stage.
- Uses valid/ready handshakes on both sides; non-memory instructions pass through unchanged in one cycle.

---
 rtl/cpu_mem_pkg.sv | 55 +++++
 rtl/cpu_mem_load_align.sv | 32 +++
 rtl/cpu_memory_stage.sv | 213 +++++++++++++++++++++
 tb/tb_cpu_memory_stage.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory stage: opcodes, exception codes,
// FSM encoding and the load/store decode helper.
package cpu_mem_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [2:0] EXC_NONE  = 3'd0;
  localparam logic [2:0] EXC_OVF   = 3'd1;
  localparam logic [2:0] EXC_ADEL  = 3'd2;
  localparam logic [2:0] EXC_ADES  = 3'd3;
  localparam logic [2:0] EXC_BUSTO = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic       is_load;
    logic       is_store;
    logic [1:0] size;
    logic       sign;
  } memop_t;

  // Classify an opcode as load/store with its access size and signedness.
  function automatic memop_t decode_memop(input logic [5:0] op);
    memop_t m;
    m = '0;
    case (op)
      OP_LB:  begin m.is_load = 1'b1;  m.size = SZ_BYTE; m.sign = 1'b1; end
      OP_LH:  begin m.is_load = 1'b1;  m.size = SZ_HALF; m.sign = 1'b1; end
      OP_LW:  begin m.is_load = 1'b1;  m.size = SZ_WORD; end
      OP_LBU: begin m.is_load = 1'b1;  m.size = SZ_BYTE; end
      OP_LHU: begin m.is_load = 1'b1;  m.size = SZ_HALF; end
      OP_SB:  begin m.is_store = 1'b1; m.size = SZ_BYTE; end
      OP_SH:  begin m.is_store = 1'b1; m.size = SZ_HALF; end
      OP_SW:  begin m.is_store = 1'b1; m.size = SZ_WORD; end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cpu_mem_load_align.sv
// Load lane selection and sign/zero extension for byte, halfword and word
// loads on a little-endian 32-bit bus.
module cpu_mem_load_align
  import cpu_mem_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed lane and extend it to 32 bits.
  always_comb begin
    case (addr_i)
      2'd0:    lane_b = rdata_i[7:0];
      2'd1:    lane_b = rdata_i[15:8];
      2'd2:    lane_b = rdata_i[23:16];
      default: lane_b = rdata_i[31:24];
    endcase
    lane_h = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SZ_BYTE: data_o = sign_i ? {{24{lane_b[7]}}, lane_b} : {24'd0, lane_b};
      SZ_HALF: data_o = sign_i ? {{16{lane_h[15]}}, lane_h} : {16'd0, lane_h};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/cpu_memory_stage.sv
// MIPS memory stage: registers the execute result, runs loads/stores over a
// req/ack bus with timeout, and presents one writeback record per instruction.
module cpu_memory_stage
  import cpu_mem_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_result,
  input  logic [31:0] in_store_data,
  input  logic        in_overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_wb_en,
  output logic [4:0]  out_wb_reg,
  output logic [2:0]  out_exc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  // Count value at which the current BUS cycle is the last one allowed.
  localparam logic [31:0] TO_LAST = 32'(BUS_TIMEOUT - 1);
  localparam logic        TO_EN   = (BUS_TIMEOUT != 0);

  state_e      state_q, state_d;
  logic [31:0] res_q, res_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_reg_q, wb_reg_d;
  logic [2:0]  exc_q, exc_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ld_q, ld_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [31:0] cnt_q, cnt_d;

  memop_t      mop;
  logic        accept;
  logic        misaligned;
  logic        go_bus;
  logic        timeout_hit;
  logic [2:0]  acc_exc;
  logic [4:0]  acc_reg;
  logic        acc_wb_en;
  logic [3:0]  acc_wstrb;
  logic [31:0] acc_wdata;
  logic [31:0] load_val;
  logic        unused_inst_bits;

  assign unused_inst_bits = ^{in_inst[25:21], in_inst[10:0]};

  assign accept      = in_valid && in_ready;
  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

  cpu_mem_load_align u_load_align (
    .addr_i  (addr_q[1:0]),
    .size_i  (size_q),
    .sign_i  (sign_q),
    .rdata_i (mem_rdata),
    .data_o  (load_val)
  );

  // Decode the incoming instruction into the record it will produce.
  always_comb begin
    mop        = decode_memop(in_inst[31:26]);
    misaligned = ((mop.size == SZ_HALF) && in_result[0]) ||
                 ((mop.size == SZ_WORD) && (in_result[1:0] != 2'd0));
    acc_exc    = EXC_NONE;
    if (in_overflow)
      acc_exc = EXC_OVF;
    else if (mop.is_load && misaligned)
      acc_exc = EXC_ADEL;
    else if (mop.is_store && misaligned)
      acc_exc = EXC_ADES;
    go_bus    = (mop.is_load || mop.is_store) && (acc_exc == EXC_NONE);
    acc_reg   = (in_inst[31:26] == 6'd0) ? in_inst[15:11] : in_inst[20:16];
    acc_wb_en = !mop.is_store && (acc_reg != 5'd0) && (acc_exc == EXC_NONE);
    acc_wstrb = 4'b0000;
    acc_wdata = 32'd0;
    if (mop.is_store) begin
      case (mop.size)
        SZ_BYTE: begin
          acc_wstrb = 4'b0001 << in_result[1:0];
          acc_wdata = {4{in_store_data[7:0]}};
        end
        SZ_HALF: begin
          acc_wstrb = in_result[1] ? 4'b1100 : 4'b0011;
          acc_wdata = {2{in_store_data[15:0]}};
        end
        default: begin
          acc_wstrb = 4'b1111;
          acc_wdata = in_store_data;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: accept into BUS or DONE, finish bus on ack or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = go_bus ? ST_BUS : ST_DONE;
      ST_BUS:  if (mem_ack || timeout_hit) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = accept ? (go_bus ? ST_BUS : ST_DONE) : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; in_ready stays low throughout the reset cycle.
  always_comb begin
    in_ready  = !rst && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
    mem_req   = (state_q == ST_BUS);
    out_valid = (state_q == ST_DONE);
  end

  // Record/bus next values: load on accept, complete or time out in BUS.
  always_comb begin
    res_d    = res_q;
    wb_en_d  = wb_en_q;
    wb_reg_d = wb_reg_q;
    exc_d    = exc_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wstrb_d  = wstrb_q;
    wdata_d  = wdata_q;
    ld_d     = ld_q;
    size_d   = size_q;
    sign_d   = sign_q;
    cnt_d    = cnt_q;
    if (accept) begin
      res_d    = in_result;
      wb_en_d  = acc_wb_en;
      wb_reg_d = acc_reg;
      exc_d    = acc_exc;
      addr_d   = in_result;
      we_d     = mop.is_store;
      wstrb_d  = acc_wstrb;
      wdata_d  = acc_wdata;
      ld_d     = mop.is_load;
      size_d   = mop.size;
      sign_d   = mop.sign;
      cnt_d    = 32'd0;
    end else if (state_q == ST_BUS) begin
      if (mem_ack) begin
        if (ld_q) res_d = load_val;
      end else if (timeout_hit) begin
        exc_d   = EXC_BUSTO;
        wb_en_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  // Record and bus registers; cleared on reset so all outputs read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q    <= '0;
      wb_en_q  <= 1'b0;
      wb_reg_q <= '0;
      exc_q    <= EXC_NONE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
      ld_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      res_q    <= res_d;
      wb_en_q  <= wb_en_d;
      wb_reg_q <= wb_reg_d;
      exc_q    <= exc_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wstrb_q  <= wstrb_d;
      wdata_q  <= wdata_d;
      ld_q     <= ld_d;
      size_q   <= size_d;
      sign_q   <= sign_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_result = res_q;
  assign out_wb_en  = wb_en_q;
  assign out_wb_reg = wb_reg_q;
  assign out_exc    = exc_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wstrb  = wstrb_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_cpu_memory_stage.sv
// Testbench for cpu_memory_stage: directed vector table, hand-written
// multi-cycle sequences, and randomized transactions against a reference model.
module tb_cpu_memory_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_result;
  logic [31:0] in_store_data;
  logic        in_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_wb_en;
  logic [4:0]  out_wb_reg;
  logic [2:0]  out_exc;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  cpu_memory_stage #(.BUS_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_result(in_result), .in_store_data(in_store_data), .in_overflow(in_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_wb_en(out_wb_en), .out_wb_reg(out_wb_reg), .out_exc(out_exc),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] res;
    logic [31:0] sd;
    logic        ovf;
    logic [31:0] rdata;
    int          delay;     // BUS cycles without ack before the ack cycle
    logic [31:0] e_result;
    logic        e_wb_en;
    logic [4:0]  e_wb_reg;
    logic [2:0]  e_exc;
    logic        e_req;
    logic        e_we;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    int          e_bc;      // expected number of cycles with mem_req high
  } vec_t;

  typedef struct {
    logic        acc;
    logic        got;
    int          lat;
    int          bc;
    logic [31:0] result;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [2:0]  exc;
    logic        req_at_valid;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic        stable;
    logic        hold_ok;
    logic        idle_after;
  } obs_t;

  task automatic chk(input string tag, input string what, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
    end
  endtask

  // Reference model: expected outcome of one instruction from the ISA rules.
  function automatic vec_t model(input logic [31:0] inst, input logic [31:0] res,
                                 input logic [31:0] sd, input logic ovf,
                                 input logic [31:0] rdata, input int delay);
    vec_t v;
    int op, nbytes, a;
    bit ld, st, sgn, aligned, tmo;
    logic [31:0] val;
    op = int'(inst >> 26);
    nbytes = 0; ld = 0; st = 0; sgn = 0;
    case (op)
      'h20: begin ld = 1; nbytes = 1; sgn = 1; end
      'h21: begin ld = 1; nbytes = 2; sgn = 1; end
      'h23: begin ld = 1; nbytes = 4; end
      'h24: begin ld = 1; nbytes = 1; end
      'h25: begin ld = 1; nbytes = 2; end
      'h28: begin st = 1; nbytes = 1; end
      'h29: begin st = 1; nbytes = 2; end
      'h2B: begin st = 1; nbytes = 4; end
      default: ;
    endcase
    a = int'(res & 32'h3);
    aligned = (nbytes == 0) || (a % nbytes == 0);
    v.inst = inst; v.res = res; v.sd = sd; v.ovf = ovf; v.rdata = rdata; v.delay = delay;
    if (ovf) v.e_exc = 3'd1;
    else if (ld && !aligned) v.e_exc = 3'd2;
    else if (st && !aligned) v.e_exc = 3'd3;
    else v.e_exc = 3'd0;
    v.e_req = (ld || st) && (v.e_exc == 3'd0);
    tmo = v.e_req && (delay >= TO);
    if (tmo) v.e_exc = 3'd4;
    v.e_bc = !v.e_req ? 0 : (tmo ? TO : delay + 1);
    v.e_wb_reg = (op == 0) ? 5'((inst >> 11) & 32'h1F) : 5'((inst >> 16) & 32'h1F);
    v.e_wb_en = !st && (v.e_wb_reg != 5'd0) && (v.e_exc == 3'd0);
    v.e_result = res;
    if (ld && v.e_req && !tmo) begin
      val = rdata >> (8 * a);
      if (nbytes == 1) begin
        val = val & 32'hFF;
        if (sgn && val >= 32'h80) val = val + 32'hFFFF_FF00;
      end else if (nbytes == 2) begin
        val = val & 32'hFFFF;
        if (sgn && val >= 32'h8000) val = val + 32'hFFFF_0000;
      end
      v.e_result = val;
    end
    v.e_we = st;
    v.e_wstrb = st ? 4'(((1 << nbytes) - 1) << a) : 4'b0000;
    if (nbytes == 1)      v.e_wdata = (sd & 32'hFF) * 32'h0101_0101;
    else if (nbytes == 2) v.e_wdata = (sd & 32'hFFFF) * 32'h0001_0001;
    else                  v.e_wdata = sd;
    return v;
  endfunction

  // Drive one instruction from IDLE, answer the bus, observe the record.
  task automatic run_txn(input vec_t v, input int stall, output obs_t o);
    int cyc, bc;
    bit got;
    o = '{default: '0};
    o.stable = 1'b1;
    o.hold_ok = 1'b1;
    bc = 0; cyc = 0; got = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_inst = v.inst; in_result = v.res;
    in_store_data = v.sd; in_overflow = v.ovf;
    out_ready = (stall == 0); mem_ack = 1'b0;
    @(negedge clk);
    o.acc = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!got && cyc < 20) begin
      cyc++;
      if (mem_req) begin
        bc++;
        if (bc == 1) begin
          o.we = mem_we; o.wstrb = mem_wstrb; o.wdata = mem_wdata; o.addr = mem_addr;
        end else if (mem_we !== o.we || mem_wstrb !== o.wstrb ||
                     mem_wdata !== o.wdata || mem_addr !== o.addr) begin
          o.stable = 1'b0;
        end
        mem_ack = (bc > v.delay);
        mem_rdata = mem_ack ? v.rdata : $urandom;
      end else begin
        mem_ack = 1'b0;
      end
      @(negedge clk);
      if (out_valid) begin
        got = 1;
        o.lat = cyc;
        o.result = out_result; o.wb_en = out_wb_en;
        o.wb_reg = out_wb_reg; o.exc = out_exc;
        o.req_at_valid = mem_req;
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    o.got = got;
    o.bc = bc;
    // at this point one posedge has passed since out_valid was seen
    for (int s = 0; s < stall && got; s++) begin
      if (!out_valid || in_ready || out_result !== o.result || out_exc !== o.exc ||
          out_wb_en !== o.wb_en || out_wb_reg !== o.wb_reg)
        o.hold_ok = 1'b0;
      @(posedge clk); #1;
    end
    if (stall > 0 && got) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
    o.idle_after = !out_valid;
  endtask

  task automatic compare(input string tag, input vec_t e, input obs_t o);
    chk(tag, "in_ready_at_accept", 32'(o.acc), 32'd1);
    chk(tag, "out_valid_seen", 32'(o.got), 32'd1);
    if (o.got) begin
      chk(tag, "exc", 32'(o.exc), 32'(e.e_exc));
      chk(tag, "wb_en", 32'(o.wb_en), 32'(e.e_wb_en));
      if (e.e_wb_en) begin
        chk(tag, "wb_reg", 32'(o.wb_reg), 32'(e.e_wb_reg));
        chk(tag, "result", o.result, e.e_result);
      end
      chk(tag, "bus_cycles", o.bc, e.e_bc);
      chk(tag, "latency", o.lat, e.e_req ? e.e_bc + 1 : 1);
      chk(tag, "req_low_at_valid", 32'(o.req_at_valid), 32'd0);
      if (e.e_req) begin
        chk(tag, "mem_addr", o.addr, e.res);
        chk(tag, "mem_we", 32'(o.we), 32'(e.e_we));
        chk(tag, "mem_wstrb", 32'(o.wstrb), 32'(e.e_wstrb));
        if (e.e_we) chk(tag, "mem_wdata", o.wdata, e.e_wdata);
        chk(tag, "bus_stable", 32'(o.stable), 32'd1);
      end
      chk(tag, "hold_stable", 32'(o.hold_ok), 32'd1);
      chk(tag, "idle_after", 32'(o.idle_after), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t tbl[17];
  vec_t v;
  obs_t o;
  logic [31:0] r_inst, r_res, r_sd, r_rd, r_sel;
  logic [5:0]  ops[12];

  initial begin
    //            inst          res           sd            ovf   rdata         dly  e_result      en    reg    exc   req   we    wstrb    wdata         bc
    tbl[0]  = '{32'h0000_1821, 32'h0000_0007, 32'h0,        1'b0, 32'h0,        0,  32'h0000_0007, 1'b1, 5'd3, 3'd0, 1'b0, 1'b0, 4'b0000, 32'h0,        0};
    tbl[1]  = '{32'h8005_0000, 32'h0000_1003, 32'h0,        1'b0, 32'h8011_2233, 2,  32'hFFFF_FF80, 1'b1, 5'd5, 3'd0, 1'b1, 1'b0, 4'b0000, 32'h0,        3};
    tbl[2]  = '{32'h9005_0000, 32'h0000_1003, 32'h0,        1'b0, 32'h8011_2233, 2,  32'h0000_0080, 1'b1, 5'd5, 3'd0, 1'b1, 1'b0, 4'b0000, 32'h0,        3};
    tbl[3]  = '{32'hA407_0000, 32'h0000_2002, 32'h1234_ABCD, 1'b0, 32'h0,        1,  32'h0,        1'b0, 5'd7, 3'd0, 1'b1, 1'b1, 4'b1100, 32'hABCD_ABCD, 2};
    tbl[4]  = '{32'h8C02_0000, 32'h0000_1002, 32'h0,        1'b0, 32'h0,        0,  32'h0,        1'b0, 5'd2, 3'd2, 1'b0, 1'b0, 4'b0000, 32'h0,        0};
    tbl[5]  = '{32'hAC04_0000, 32'h0000_1001, 32'h0,        1'b0, 32'h0,        0,  32'h0,        1'b0, 5'd4, 3'd3, 1'b0, 1'b0, 4'b0000, 32'h0,        0};
    tbl[6]  = '{32'h0000_4820, 32'h0000_0005, 32'h0,        1'b1, 32'h0,        0,  32'h0,        1'b0, 5'd9, 3'd1, 1'b0, 1'b0, 4'b0000, 32'h0,        0};
    tbl[7]  = '{32'h8406_0000, 32'h0000_3002, 32'h0,        1'b0, 32'h8001_1234, 0,  32'hFFFF_8001, 1'b1, 5'd6, 3'd0, 1'b1, 1'b0, 4'b0000, 32'h0,        1};
    tbl[8]  = '{32'h9406_0000, 32'h0000_3002, 32'h0,        1'b0, 32'h8001_1234, 0,  32'h0000_8001, 1'b1, 5'd6, 3'd0, 1'b1, 1'b0, 4'b0000, 32'h0,        1};
    tbl[9]  = '{32'hA001_0000, 32'h0000_0011, 32'hCAFE_00EE, 1'b0, 32'h0,        1,  32'h0,        1'b0, 5'd1, 3'd0, 1'b1, 1'b1, 4'b0010, 32'hEEEE_EEEE, 2};
    tbl[10] = '{32'hAC04_0000, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 32'h0,        0,  32'h0,        1'b0, 5'd4, 3'd0, 1'b1, 1'b1, 4'b1111, 32'hDEAD_BEEF, 1};
    tbl[11] = '{32'h8C02_0000, 32'h0000_0100, 32'h0,        1'b0, 32'h0,        99, 32'h0,        1'b0, 5'd2, 3'd4, 1'b1, 1'b0, 4'b0000, 32'h0,        4};
    tbl[12] = '{32'h8C02_0000, 32'h0000_0104, 32'h0,        1'b0, 32'h1357_9BDF, 3,  32'h1357_9BDF, 1'b1, 5'd2, 3'd0, 1'b1, 1'b0, 4'b0000, 32'h0,        4};
    tbl[13] = '{32'h0000_0021, 32'h0000_0005, 32'h0,        1'b0, 32'h0,        0,  32'h0,        1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 4'b0000, 32'h0,        0};
    tbl[14] = '{32'h3C08_0000, 32'hABCD_0000, 32'h0,        1'b0, 32'h0,        0,  32'hABCD_0000, 1'b1, 5'd8, 3'd0, 1'b0, 1'b0, 4'b0000, 32'h0,        0};
    tbl[15] = '{32'h8005_0000, 32'h0000_1000, 32'h0,        1'b1, 32'h0,        0,  32'h0,        1'b0, 5'd5, 3'd1, 1'b0, 1'b0, 4'b0000, 32'h0,        0};
    tbl[16] = '{32'hA407_0000, 32'h0000_2001, 32'h0,        1'b0, 32'h0,        0,  32'h0,        1'b0, 5'd7, 3'd3, 1'b0, 1'b0, 4'b0000, 32'h0,        0};

    ops = '{6'h00, 6'h09, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h0D};

    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_result = '0; in_store_data = '0;
    in_overflow = 1'b0; out_ready = 1'b1; mem_ack = 1'b0; mem_rdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", "in_ready_during_rst", 32'(in_ready), 32'd0);
    chk("reset", "out_valid", 32'(out_valid), 32'd0);
    chk("reset", "mem_req", 32'(mem_req), 32'd0);
    chk("reset", "out_result", out_result, 32'd0);
    chk("reset", "out_exc_wb", {out_exc, out_wb_en, out_wb_reg}, 32'd0);
    chk("reset", "mem_bus", {mem_we, mem_wstrb} | mem_addr | mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset", "in_ready_after_rst", 32'(in_ready), 32'd1);

    // Directed vector table
    foreach (tbl[i]) begin
      run_txn(tbl[i], i % 3, o);
      compare($sformatf("vec%0d", i), tbl[i], o);
    end

    // Reset while in BUS: request drops, late ack yields nothing
    @(posedge clk); #1;
    in_valid = 1'b1; in_inst = 32'h8C02_0000; in_result = 32'h0000_0300; in_overflow = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_bus", "mem_req_before", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_bus", "mem_req_after", 32'(mem_req), 32'd0);
    chk("rst_bus", "out_valid_after", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'hFEED_F00D;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_bus", "late_ack_no_output", 32'({out_valid, mem_req}), 32'd0);
    end

    // Back-to-back ADD then LW with writeback stalled for 3 cycles
    @(posedge clk); #1;
    in_valid = 1'b1; in_inst = 32'h0000_4820; in_result = 32'h0000_0011; in_overflow = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("b2b", "in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_inst = 32'h8C02_0000; in_result = 32'h0000_0200;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("b2b", "held_valid", 32'(out_valid), 32'd1);
      chk("b2b", "held_in_ready", 32'(in_ready), 32'd0);
      chk("b2b", "held_record", {out_result[15:0], 3'd0, out_wb_en, 3'd0, out_wb_reg, 1'b0, out_exc},
          {16'h0011, 3'd0, 1'b1, 3'd0, 5'd9, 1'b0, 3'd0});
      chk("b2b", "held_no_req", 32'(mem_req), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("b2b", "in_ready_on_release", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b", "lw_req", 32'(mem_req), 32'd1);
    chk("b2b", "lw_addr", mem_addr, 32'h0000_0200);
    chk("b2b", "lw_no_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h0000_0055;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("b2b", "lw_valid", 32'(out_valid), 32'd1);
    chk("b2b", "lw_result", out_result, 32'h0000_0055);
    chk("b2b", "lw_wb", {out_wb_en, out_wb_reg, out_exc}, {1'b1, 5'd2, 3'd0});
    @(posedge clk); #1;

    // Randomized transactions against the reference model
    for (int n = 0; n < 200; n++) begin
      r_inst = $urandom; r_res = $urandom; r_sd = $urandom; r_rd = $urandom;
      r_sel = $urandom_range(0, 11);
      r_inst[31:26] = ops[r_sel];
      v = model(r_inst, r_res, r_sd, ($urandom_range(0, 7) == 0), r_rd,
                $urandom_range(0, 5));
      run_txn(v, $urandom_range(0, 2), o);
      compare($sformatf("rnd%0d", n), v, o);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
